pic_sdram_writer: RTL and testbench

PIC_SDRAM_WRITER -- requirements
Module: pic_sdram_writer

---
 rtl/pic_sdram_writer.sv | 193 +++++++++++++++++++
 tb/tb_pic_sdram_writer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_sdram_writer.sv
// Buffers pixel words from the SD picture loader in a FWFT FIFO and issues SDRAM burst
// writes, flushing the previous picture's tail before rebasing to a new picture address.
module pic_sdram_writer #(
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [23:0] base_addr,
  input  logic        pic_switch,
  input  logic        load_done,
  output logic        burst_req,
  output logic [23:0] burst_addr,
  output logic [8:0]  burst_len,
  input  logic        burst_ack,
  input  logic        data_rd,
  output logic [15:0] data_out,
  input  logic        burst_done,
  output logic        fifo_ovf,
  output logic        all_written
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] old_cnt_q, old_cnt_d;
  logic [23:0]   cur_addr_q, cur_addr_d;
  logic [23:0]   pend_base_q, pend_base_d;
  logic          flush_pend_q, flush_pend_d;
  logic          burst_req_q, burst_req_d;
  logic [23:0]   burst_addr_q, burst_addr_d;
  logic [8:0]    burst_len_q, burst_len_d;
  logic          fifo_ovf_q, fifo_ovf_d;
  logic          all_written_q, all_written_d;

  logic full_c, empty_c, push_c, pop_c;

  assign full_c  = (count_q == DEPTH_C);
  assign empty_c = (count_q == '0);
  assign push_c  = wr_en && !full_c;
  assign pop_c   = data_rd && !empty_c;

  assign burst_req   = burst_req_q;
  assign burst_addr  = burst_addr_q;
  assign burst_len   = burst_len_q;
  assign data_out    = mem_q[rd_ptr_q];
  assign fifo_ovf    = fifo_ovf_q;
  assign all_written = all_written_q;

  // FIFO storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    old_cnt_d     = old_cnt_q;
    cur_addr_d    = cur_addr_q;
    pend_base_d   = pend_base_q;
    flush_pend_d  = flush_pend_q;
    burst_req_d   = burst_req_q;
    burst_addr_d  = burst_addr_q;
    burst_len_d   = burst_len_q;
    fifo_ovf_d    = fifo_ovf_q;
    all_written_d = 1'b0;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (wr_en && full_c) begin
      fifo_ovf_d = 1'b1;
    end
    if (flush_pend_q && pop_c && (old_cnt_q != '0)) begin
      old_cnt_d = old_cnt_q - CW'(1);
    end

    // While a flush is pending, bursts are capped at the old picture's remaining words
    // so no burst ever straddles two pictures.
    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          if (old_cnt_q == '0) begin
            cur_addr_d   = pend_base_q;
            flush_pend_d = 1'b0;
          end else begin
            state_d      = ST_REQ;
            burst_req_d  = 1'b1;
            burst_addr_d = cur_addr_q;
            burst_len_d  = 9'((old_cnt_q < BL_C) ? old_cnt_q : BL_C);
          end
        end else if (count_q >= BL_C) begin
          state_d      = ST_REQ;
          burst_req_d  = 1'b1;
          burst_addr_d = cur_addr_q;
          burst_len_d  = 9'(BL_C);
        end else if (load_done && (count_q != '0)) begin
          state_d      = ST_REQ;
          burst_req_d  = 1'b1;
          burst_addr_d = cur_addr_q;
          burst_len_d  = 9'((count_q < BL_C) ? count_q : BL_C);
        end
      end
      ST_REQ: begin
        if (burst_ack) begin
          state_d     = ST_XFER;
          burst_req_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (burst_done) begin
          state_d    = ST_IDLE;
          cur_addr_d = cur_addr_q + 24'(burst_len_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Picture switch: words already in the FIFO (including this cycle's write) belong
    // to the old picture; an empty idle FIFO rebases immediately.
    if (pic_switch) begin
      pend_base_d = base_addr;
      if (flush_pend_q && (old_cnt_q != '0)) begin
        flush_pend_d = 1'b1;
      end else if ((state_q == ST_IDLE) && (state_d == ST_IDLE) && (count_d == '0)) begin
        cur_addr_d   = base_addr;
        flush_pend_d = 1'b0;
        old_cnt_d    = '0;
      end else begin
        flush_pend_d = 1'b1;
        old_cnt_d    = count_d;
      end
    end

    all_written_d = load_done && (count_d == '0) && (state_d == ST_IDLE) && !flush_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      old_cnt_q     <= '0;
      cur_addr_q    <= '0;
      pend_base_q   <= '0;
      flush_pend_q  <= 1'b0;
      burst_req_q   <= 1'b0;
      burst_addr_q  <= '0;
      burst_len_q   <= '0;
      fifo_ovf_q    <= 1'b0;
      all_written_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      old_cnt_q     <= old_cnt_d;
      cur_addr_q    <= cur_addr_d;
      pend_base_q   <= pend_base_d;
      flush_pend_q  <= flush_pend_d;
      burst_req_q   <= burst_req_d;
      burst_addr_q  <= burst_addr_d;
      burst_len_q   <= burst_len_d;
      fifo_ovf_q    <= fifo_ovf_d;
      all_written_q <= all_written_d;
    end
  end

endmodule

// File: tb/tb_pic_sdram_writer.sv
// Bench for pic_sdram_writer: directed burst/flush/overflow/reset scenarios, then a
// randomized multi-picture run checked against an address-indexed SDRAM image model.
module tb_pic_sdram_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [23:0] base_addr;
  logic        pic_switch;
  logic        load_done;
  logic        burst_req;
  logic [23:0] burst_addr;
  logic [8:0]  burst_len;
  logic        burst_ack;
  logic        data_rd;
  logic [15:0] data_out;
  logic        burst_done;
  logic        fifo_ovf;
  logic        all_written;

  pic_sdram_writer #(.BURST_LEN(256), .FIFO_DEPTH(512)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .base_addr(base_addr),
    .pic_switch(pic_switch), .load_done(load_done), .burst_req(burst_req),
    .burst_addr(burst_addr), .burst_len(burst_len), .burst_ack(burst_ack),
    .data_rd(data_rd), .data_out(data_out), .burst_done(burst_done),
    .fifo_ovf(fifo_ovf), .all_written(all_written)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_mem [int unsigned];
  logic [15:0] got_mem [int unsigned];
  int          dup = 0;
  bit          rnd_done = 1'b0;

  // writer-thread state
  int unsigned w_base, w_cur_base, w_k, w_nw;
  // controller-thread state
  int unsigned c_addr, c_len, c_i, c_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0; pic_switch = 1'b0; load_done = 1'b0;
    burst_ack = 1'b0; data_rd = 1'b0; burst_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = 16'($urandom);
      exp_q.push_back(wr_data);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic pic(input logic [23:0] b);
    pic_switch = 1'b1;
    base_addr = b;
    @(negedge clk);
    pic_switch = 1'b0;
  endtask

  // Controller model for directed tests: wait for a request, hold off ack, pop and compare.
  task automatic serve(input string tag, input int ack_delay, input logic [23:0] eaddr,
                       input logic [8:0] elen);
    int n;
    logic [23:0] a;
    logic [8:0] l;
    bit stable;
    logic [15:0] w;
    n = 0;
    while (burst_req !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(burst_req), 32'd1);
    if (burst_req !== 1'b1) return;
    check({tag, "_addr"}, 32'(burst_addr), 32'(eaddr));
    check({tag, "_len"}, 32'(burst_len), 32'(elen));
    a = burst_addr;
    l = burst_len;
    stable = 1'b1;
    repeat (ack_delay) begin
      @(negedge clk);
      if (burst_req !== 1'b1 || burst_addr !== a || burst_len !== l) stable = 1'b0;
    end
    check({tag, "_stable"}, 32'(stable), 32'd1);
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    check({tag, "_req_drop"}, 32'(burst_req), 32'd0);
    for (int i = 0; i < int'(l); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      data_rd = 1'b1;
      check({tag, "_data"}, 32'(data_out), 32'(w));
      @(negedge clk);
    end
    data_rd = 1'b0;
    burst_done = 1'b1;
    @(negedge clk);
    burst_done = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] obs;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_data = '0; base_addr = '0; pic_switch = 1'b0; load_done = 1'b0;
    burst_ack = 1'b0; data_rd = 1'b0; burst_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(burst_req), 32'd0);
    check("rst_addr", 32'(burst_addr), 32'd0);
    check("rst_len", 32'(burst_len), 32'd0);
    check("rst_ovf", 32'(fifo_ovf), 32'd0);
    check("rst_allw", 32'(all_written), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full burst, picture switch with 44-word tail, next picture at new base
    pic(24'h000000);
    write_n(300);
    pic(24'h26F400);
    serve("b0", 50, 24'h000000, 9'd256);
    serve("b1", 3, 24'h000100, 9'd44);
    write_n(256);
    serve("b2", 0, 24'h26F400, 9'd256);

    // Overflow: 513 writes with no pops
    do_reset();
    write_n(512);
    check("ovf_before", 32'(fifo_ovf), 32'd0);
    wr_en = 1'b1; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_after", 32'(fifo_ovf), 32'd1);
    serve("ov0", 0, 24'h000000, 9'd256);
    serve("ov1", 0, 24'h000100, 9'd256);
    repeat (20) @(negedge clk);
    check("ov_no_req", 32'(burst_req), 32'd0);
    check("ov_sticky", 32'(fifo_ovf), 32'd1);

    // Partial burst on load_done, immediate rebase on an empty FIFO
    do_reset();
    pic(24'h123456);
    write_n(100);
    repeat (10) @(negedge clk);
    check("ld_no_req", 32'(burst_req), 32'd0);
    check("ld_allw0", 32'(all_written), 32'd0);
    load_done = 1'b1;
    @(negedge clk);
    check("ld_allw_busy", 32'(all_written), 32'd0);
    serve("ld", 2, 24'h123456, 9'd100);
    repeat (2) @(negedge clk);
    check("ld_allw1", 32'(all_written), 32'd1);
    load_done = 1'b0;
    repeat (2) @(negedge clk);
    check("ld_allw_drop", 32'(all_written), 32'd0);

    // Reset in the middle of a transfer
    do_reset();
    write_n(256);
    n = 0;
    while (burst_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mr_req", 32'(burst_req), 32'd1);
    burst_ack = 1'b1;
    @(negedge clk);
    burst_ack = 1'b0;
    repeat (10) begin
      data_rd = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    data_rd = 1'b0;
    #1;
    check("mr_rst_req", 32'(burst_req), 32'd0);
    check("mr_rst_addr", 32'(burst_addr), 32'd0);
    check("mr_rst_len", 32'(burst_len), 32'd0);
    check("mr_rst_allw", 32'(all_written), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    write_n(255);
    repeat (20) @(negedge clk);
    check("mr_no_req", 32'(burst_req), 32'd0);
    write_n(1);
    serve("mr", 0, 24'h000000, 9'd256);

    // Randomized multi-picture run against an SDRAM image model
    do_reset();
    fork
      begin
        w_cur_base = 0;
        w_k = 0;
        for (int p = 0; p < 5; p++) begin
          w_base = (p == 4) ? 32'hFFFF80 : ((p + 1) * 32'h200000 + $urandom_range(0, 32'hFFFF));
          pic_switch = 1'b1;
          base_addr = 24'(w_base);
          if (p > 0 && $urandom_range(0, 1) == 1) begin
            wr_en = 1'b1;
            wr_data = 16'($urandom);
            exp_mem[(w_cur_base + w_k) & 32'hFFFFFF] = wr_data;
            w_k++;
          end
          @(negedge clk);
          pic_switch = 1'b0;
          wr_en = 1'b0;
          w_cur_base = w_base;
          w_k = 0;
          w_nw = $urandom_range(300, 600);
          for (int i = 0; i < int'(w_nw); i++) begin
            repeat ($urandom_range(2, 5)) @(negedge clk);
            wr_en = 1'b1;
            wr_data = 16'($urandom);
            exp_mem[(w_cur_base + w_k) & 32'hFFFFFF] = wr_data;
            w_k++;
            @(negedge clk);
            wr_en = 1'b0;
          end
        end
        load_done = 1'b1;
        n = 0;
        while (all_written !== 1'b1 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        check("rnd_all_written", 32'(all_written), 32'd1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          if (burst_req === 1'b1) begin
            c_addr = 32'(burst_addr);
            c_len = 32'(burst_len);
            repeat ($urandom_range(0, 8)) @(negedge clk);
            burst_ack = 1'b1;
            @(negedge clk);
            burst_ack = 1'b0;
            c_i = 0;
            while (c_i < c_len) begin
              if ($urandom_range(0, 3) != 0) begin
                data_rd = 1'b1;
                c_a = (c_addr + c_i) & 32'hFFFFFF;
                if (got_mem.exists(c_a)) dup++;
                got_mem[c_a] = data_out;
                c_i++;
              end else begin
                data_rd = 1'b0;
              end
              @(negedge clk);
            end
            data_rd = 1'b0;
            burst_done = 1'b1;
            @(negedge clk);
            burst_done = 1'b0;
          end
        end
      end
    join

    foreach (exp_mem[a]) begin
      obs = got_mem.exists(a) ? 32'(got_mem[a]) : 32'hxxxxxxxx;
      check("rnd_word", obs, 32'(exp_mem[a]));
    end
    check("rnd_word_count", 32'(got_mem.size()), 32'(exp_mem.size()));
    check("rnd_dup", 32'(dup), 32'd0);
    check("rnd_ovf", 32'(fifo_ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
